input_port_controller: RTL

- Per-input-port stage of the mesh router, directly upstream of HeadFlitDecoder.
- Buffers incoming flits in a FIFO and, for every packet, presents the head flit to the decoder and latches the returned RequestMessage.
- Requests the switch allocator with that port code, then streams the packet's flits to the crossbar until the tail flit leaves.
- Releases the allocation and returns to idle after the tail.

---
 rtl/input_port_controller.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/input_port_controller.sv
// input_port_controller: per-input-port stage of the mesh router.
// Buffers incoming flits in a first-word-fall-through FIFO, hands each packet's
// head flit to the head-flit decoder, requests the switch allocator with the
// decoded port code, then streams the packet to the crossbar until its tail.
// Optional feature: define INPUT_PORT_PKT_COUNT_EN to add the pkt_count output
// (saturating count of packets forwarded).
// `release` is a reserved word, so the release pulse port is named releasePulse.
module input_port_controller #(
    parameter int unsigned N             = 4,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned REQUEST_WIDTH = 3,
    parameter int unsigned BUFFER_DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_WIDTH-1:0]    HeadFlit,
    output logic                     decodeHeadFlit,
    input  logic                     headFlitDecoded,
    input  logic [REQUEST_WIDTH-1:0] RequestMessage,
    output logic [REQUEST_WIDTH-1:0] request,
    output logic                     request_valid,
    input  logic                     grant,
    output logic                     releasePulse,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
`ifdef INPUT_PORT_PKT_COUNT_EN
    output logic [15:0]              pkt_count,
`endif
    output logic                     proto_err
);

    localparam int unsigned PTR_W = $clog2(BUFFER_DEPTH);
    localparam int unsigned CNT_W = $clog2(BUFFER_DEPTH + 1);

    // Reject configurations the pointer arithmetic cannot support
    if (N < 1 || BUFFER_DEPTH < 2 || (BUFFER_DEPTH & (BUFFER_DEPTH - 1)) != 0) begin : gBadParams
        $error("input_port_controller: N must be >= 1, BUFFER_DEPTH a power of two >= 2");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DECODE  = 2'd1,
        REQUEST = 2'd2,
        FORWARD = 2'd3
    } stateT;

    logic [DATA_WIDTH-1:0]    fifoMem [BUFFER_DEPTH];
    logic [PTR_W-1:0]         wrPtr;
    logic [PTR_W-1:0]         rdPtr;
    logic [CNT_W-1:0]         count;
    stateT                    state;
    logic [REQUEST_WIDTH-1:0] requestReg;
    logic                     releaseReg;
    logic                     protoErrReg;

    logic                     full;
    logic                     empty;
    logic [DATA_WIDTH-1:0]    headEntry;
    logic [1:0]               headType;
    logic                     headIsStart;
    logic                     headIsEnd;
    logic                     push;
    logic                     fwdPop;
    logic                     dropPop;
    logic                     pop;

    assign full      = (count == CNT_W'(BUFFER_DEPTH));
    assign empty     = (count == '0);
    assign headEntry = fifoMem[rdPtr];
    assign headType  = headEntry[DATA_WIDTH-1 -: 2];
    // Type encoding: bit 0 marks a packet start (head / head-tail), bit 1 a packet end (tail / head-tail)
    assign headIsStart = headType[0];
    assign headIsEnd   = headType[1];

    assign push    = in_valid && !full;
    assign fwdPop  = (state == FORWARD) && !empty && out_ready;
    assign dropPop = (state == IDLE) && !empty && !headIsStart;
    assign pop     = fwdPop || dropPop;

    // FIFO storage; contents need no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem[wrPtr] <= in_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Packet control: decode head, request allocator, forward until tail
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            requestReg  <= '0;
            releaseReg  <= 1'b0;
            protoErrReg <= 1'b0;
        end else begin
            releaseReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        if (headIsStart) begin
                            state <= DECODE;
                        end else begin
                            protoErrReg <= 1'b1;
                        end
                    end
                end
                DECODE: begin
                    if (headFlitDecoded) begin
                        requestReg <= RequestMessage;
                        state      <= REQUEST;
                    end
                end
                REQUEST: begin
                    if (grant) begin
                        state <= FORWARD;
                    end
                end
                FORWARD: begin
                    if (fwdPop && headIsEnd) begin
                        releaseReg <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef INPUT_PORT_PKT_COUNT_EN
    logic [15:0] pktCount;

    // Saturating count of packets whose tail has left the port
    always_ff @(posedge clk) begin
        if (rst) begin
            pktCount <= '0;
        end else if (fwdPop && headIsEnd && (pktCount != 16'hFFFF)) begin
            pktCount <= pktCount + 16'd1;
        end
    end

    assign pkt_count = pktCount;
`endif

    assign in_ready       = !full;
    assign HeadFlit       = headEntry;
    assign decodeHeadFlit = (state == DECODE);
    assign request        = requestReg;
    assign request_valid  = (state == REQUEST);
    assign out_valid      = (state == FORWARD) && !empty;
    assign out_data       = headEntry;
    assign releasePulse   = releaseReg;
    assign proto_err      = protoErrReg;

endmodule
